muldiv_ctrl: RTL

Sequencer for the shared multiply/divide datapath. Accepts MULT/DIV/MTHI/MTLO requests from the main control FSM, launches the multiplier or divider with a one-cycle start pulse, waits for its done flag, and commits the result into architectural HI/LO registers. Provides the busy stall, divide-by-zero, and timeout indications the control FSM uses for stalls and exceptions.

---
 rtl/muldiv_ctrl_pkg.sv | 38 +++
 rtl/muldiv_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_ctrl_pkg;

   localparam int WORD = 32;

   // Sequencer state encoding
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MULT_RUN = 2'd1,
      DIV_RUN  = 2'd2,
      COMMIT   = 2'd3
   } state_t;

   // Request types as resolved in IDLE, after priority is applied
   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIV0  = 3'd3,
      OP_WRITE = 3'd4
   } op_t;

   // Resolve coincident requests: multiply beats divide beats HI/LO writes.
   // A zero divisor turns the divide into a rejected request.
   function automatic op_t sel_op(input logic rm, input logic rd,
                                  input logic wh, input logic wl,
                                  input logic [WORD-1:0] b);
      if (rm)
         return OP_MULT;
      else if (rd)
         return (b == '0) ? OP_DIV0 : OP_DIV;
      else if (wh || wl)
         return OP_WRITE;
      else
         return OP_NONE;
   endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: launches a unit, waits for done, commits HI/LO,
// and reports div0 / timeout to the main control FSM.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_mult,
   input  logic            req_div,
   input  logic [WORD-1:0] op_a,
   input  logic [WORD-1:0] op_b,
   input  logic            wr_hi,
   input  logic            wr_lo,
   input  logic [WORD-1:0] wr_data,
   output logic            mult_start,
   output logic            div_start,
   output logic [WORD-1:0] unit_a,
   output logic [WORD-1:0] unit_b,
   input  logic            mult_done,
   input  logic [WORD-1:0] mult_hi,
   input  logic [WORD-1:0] mult_lo,
   input  logic            div_done,
   input  logic [WORD-1:0] div_hi,
   input  logic [WORD-1:0] div_lo,
   output logic [WORD-1:0] hi_out,
   output logic [WORD-1:0] lo_out,
   output logic            busy,
   output logic            done,
   output logic            div0,
   output logic            timeout
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [WORD-1:0] hi_n, lo_n, ua_n, ub_n;
   logic            mstart_n, dstart_n, div0_n, tmo_n;

   // Next-state and next-register values; registers hold unless updated here.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      hi_n     = hi_out;
      lo_n     = lo_out;
      ua_n     = unit_a;
      ub_n     = unit_b;
      mstart_n = 1'b0;
      dstart_n = 1'b0;
      div0_n   = 1'b0;
      tmo_n    = 1'b0;
      case (state)
         IDLE: begin
            case (sel_op(req_mult, req_div, wr_hi, wr_lo, op_b))
               OP_MULT: begin
                  state_n  = MULT_RUN;
                  ua_n     = op_a;
                  ub_n     = op_b;
                  cnt_n    = '0;
                  mstart_n = 1'b1;
               end
               OP_DIV: begin
                  state_n  = DIV_RUN;
                  ua_n     = op_a;
                  ub_n     = op_b;
                  cnt_n    = '0;
                  dstart_n = 1'b1;
               end
               OP_DIV0: div0_n = 1'b1;
               OP_WRITE: begin
                  if (wr_hi) hi_n = wr_data;
                  if (wr_lo) lo_n = wr_data;
               end
               default: ;
            endcase
         end
         MULT_RUN: begin
            // done wins over an expiring counter on the same edge
            if (mult_done) begin
               hi_n    = mult_hi;
               lo_n    = mult_lo;
               state_n = COMMIT;
            end else if (cnt == TMAX) begin
               state_n = IDLE;
               tmo_n   = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DIV_RUN: begin
            if (div_done) begin
               hi_n    = div_hi;
               lo_n    = div_lo;
               state_n = COMMIT;
            end else if (cnt == TMAX) begin
               state_n = IDLE;
               tmo_n   = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         COMMIT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State, counter, HI/LO, operand latches and one-cycle pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         hi_out     <= '0;
         lo_out     <= '0;
         unit_a     <= '0;
         unit_b     <= '0;
         mult_start <= 1'b0;
         div_start  <= 1'b0;
         div0       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         hi_out     <= hi_n;
         lo_out     <= lo_n;
         unit_a     <= ua_n;
         unit_b     <= ub_n;
         mult_start <= mstart_n;
         div_start  <= dstart_n;
         div0       <= div0_n;
         timeout    <= tmo_n;
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == COMMIT);

endmodule
